br_target_buf: RTL and testbench

Direct-mapped branch target buffer in the fetch stage, beside the counter-based direction predictor. For each fetched branch address it reports whether a target is cached and what that target is. The next-PC selector combines `hit`/`target` with the predictor's `pred_taken` output. The buffer is trained from commit with resolved taken branches.

---
 rtl/br_target_buf_if.sv | 25 ++
 rtl/br_target_buf.sv | 123 ++++++++++++
 tb/tb_br_target_buf.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/br_target_buf_if.sv
// Lookup/update bus of the branch target buffer.
// master: fetch/commit side that issues lookups and training updates.
// slave : the buffer itself, which returns hit/target.
interface br_target_buf_if #(
  parameter int ADDR = 32
);
  logic            lk_;
  logic [ADDR-1:0] lk_addr;
  logic            hit;
  logic [ADDR-1:0] target;
  logic            upd_;
  logic [ADDR-1:0] upd_addr;
  logic [ADDR-1:0] upd_target;
  logic            upd_taken_;

  modport master (
    output lk_, lk_addr, upd_, upd_addr, upd_target, upd_taken_,
    input  hit, target
  );

  modport slave (
    input  lk_, lk_addr, upd_, upd_addr, upd_target, upd_taken_,
    output hit, target
  );
endinterface

// File: rtl/br_target_buf.sv
// Direct-mapped branch target buffer for the fetch stage.
// Lookups report whether a target is cached for a branch address; commit
// trains the table with resolved taken branches; inv_ (fence.i) clears it.
// Optional feature macro: BTB_OUTREG_EN -- when defined, hit/target come
// from an output register (1-cycle latency, cleared by flush_); otherwise
// they are combinational and flush_ is ignored.
module br_target_buf #(
  parameter int ADDR     = 32,
  parameter int BTB_D    = 64,
  parameter int ADDR_OFS = 2
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             flush_,
  input  logic             inv_,
  br_target_buf_if.slave   bus
);

  localparam int IDX  = $clog2(BTB_D);
  localparam int TAGW = ADDR - IDX - ADDR_OFS;

  // Table storage: only the valid bits are reset; tag/target are qualified
  // by valid so they can stay plain RAM-style storage.
  logic [BTB_D-1:0] valid;
  logic [TAGW-1:0]  tag_mem [BTB_D];
  logic [ADDR-1:0]  tgt_mem [BTB_D];

  // Address split for lookup and update ports.
  logic [IDX-1:0]   lk_idx;
  logic [TAGW-1:0]  lk_tag;
  logic [IDX-1:0]   upd_idx;
  logic [TAGW-1:0]  upd_tag;

  assign lk_idx  = bus.lk_addr[IDX+ADDR_OFS-1:ADDR_OFS];
  assign lk_tag  = bus.lk_addr[ADDR-1:IDX+ADDR_OFS];
  assign upd_idx = bus.upd_addr[IDX+ADDR_OFS-1:ADDR_OFS];
  assign upd_tag = bus.upd_addr[ADDR-1:IDX+ADDR_OFS];

  // Instruction-offset bits never select an entry; flush_ only matters
  // when the output register is built.
  logic unused_bits;
  assign unused_bits = &{1'b0, flush_,
                         bus.lk_addr[ADDR_OFS-1:0],
                         bus.upd_addr[ADDR_OFS-1:0]};

  // Write enable: taken commit update, dropped when an invalidate coincides.
  logic wr_en;
  assign wr_en = (!bus.upd_) && (!bus.upd_taken_) && inv_;

  // Valid bits: async clear on reset, bulk clear on inv_, set on a taken update.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      valid <= {BTB_D{1'b0}};
    end else if (!inv_) begin
      valid <= {BTB_D{1'b0}};
    end else if (wr_en) begin
      valid[upd_idx] <= 1'b1;
    end else begin
      valid <= valid;
    end
  end

  // Tag and target payload: written on a taken update, overwriting any alias.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[upd_idx] <= upd_tag;
      tgt_mem[upd_idx] <= bus.upd_target;
    end else begin
      tag_mem[upd_idx] <= tag_mem[upd_idx];
      tgt_mem[upd_idx] <= tgt_mem[upd_idx];
    end
  end

  // Lookup against the pre-edge table: requested, valid and tag-equal.
  logic            hit_c;
  logic [ADDR-1:0] target_c;

  // Hit detection for the current lookup request.
  always_comb begin
    hit_c = 1'b0;
    if ((!bus.lk_) && valid[lk_idx] && (tag_mem[lk_idx] == lk_tag)) begin
      hit_c = 1'b1;
    end else begin
      hit_c = 1'b0;
    end
  end

  // Target is forced to zero on a miss so the next-PC mux sees a clean value.
  always_comb begin
    target_c = {ADDR{1'b0}};
    if (hit_c) begin
      target_c = tgt_mem[lk_idx];
    end else begin
      target_c = {ADDR{1'b0}};
    end
  end

`ifdef BTB_OUTREG_EN
  logic            hit_q;
  logic [ADDR-1:0] target_q;

  // Output register: captures this cycle's lookup; flush_ drops it.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      hit_q    <= 1'b0;
      target_q <= {ADDR{1'b0}};
    end else if (!flush_) begin
      hit_q    <= 1'b0;
      target_q <= {ADDR{1'b0}};
    end else begin
      hit_q    <= hit_c;
      target_q <= target_c;
    end
  end

  assign bus.hit    = hit_q;
  assign bus.target = target_q;
`else
  assign bus.hit    = hit_c;
  assign bus.target = target_c;
`endif

endmodule

// File: tb/tb_br_target_buf.sv
// Self-checking bench for br_target_buf (ADDR=32, BTB_D=64, ADDR_OFS=2).
// Works in both output modes; define BTB_OUTREG_EN for the registered build.
module tb_br_target_buf;

`ifdef BTB_OUTREG_EN
  localparam bit REG_MODE = 1'b1;
`else
  localparam bit REG_MODE = 1'b0;
`endif

  logic clk;
  logic reset_;
  logic flush_;
  logic inv_;

  br_target_buf_if #(.ADDR(32)) bus ();

  br_target_buf #(.ADDR(32), .BTB_D(64), .ADDR_OFS(2)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .flush_ (flush_),
    .inv_   (inv_),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          lk;
    logic [31:0] la;
    bit          upd;
    logic [31:0] ua;
    logic [31:0] ut;
    bit          taken;
    bit          inv;
    bit          flush;
    bit          ehit;
    logic [31:0] etgt;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(bit lk, logic [31:0] la, bit upd, logic [31:0] ua,
                              logic [31:0] ut, bit taken, bit inv, bit flush,
                              bit ehit, logic [31:0] etgt);
    vec_t v;
    v.lk = lk; v.la = la; v.upd = upd; v.ua = ua; v.ut = ut;
    v.taken = taken; v.inv = inv; v.flush = flush; v.ehit = ehit; v.etgt = etgt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic eh, input logic [31:0] et);
    checks++;
    if ((bus.hit !== eh) || (bus.target !== et)) begin
      failures++;
      $display("FAIL %s: got hit=%0b target=%h, expected hit=%0b target=%h",
               nm, bus.hit, bus.target, eh, et);
    end
  endtask

  // Drive one cycle of inputs (active-high fields inverted onto the _ pins),
  // then check the result of that cycle's lookup at the mode's latency.
  task automatic step(input vec_t v, input string nm);
    bus.lk_        = ~v.lk;
    bus.lk_addr    = v.la;
    bus.upd_       = ~v.upd;
    bus.upd_addr   = v.ua;
    bus.upd_target = v.ut;
    bus.upd_taken_ = ~v.taken;
    inv_           = ~v.inv;
    flush_         = ~v.flush;
    if (!REG_MODE) begin
      #1;
      chk(nm, v.ehit, v.etgt);
    end
    @(posedge clk);
    #1;
    if (REG_MODE) begin
      chk(nm, v.ehit, v.etgt);
    end
  endtask

  initial begin
    //               lk  la            upd ua            ut            tk  inv fl  hit exp_tgt
    vecs[0]  = mk(1, 32'h0000_0100, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 32'h0,         1, 32'h0000_0100, 32'h0000_2000, 1, 0, 0, 0, 32'h0);
    vecs[2]  = mk(1, 32'h0000_0100, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0000_2000);
    vecs[3]  = mk(1, 32'h0000_0102, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0000_2000);
    vecs[4]  = mk(1, 32'h0000_0200, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
    vecs[5]  = mk(0, 32'h0,         1, 32'h0000_0200, 32'h0000_3000, 1, 0, 0, 0, 32'h0);
    vecs[6]  = mk(1, 32'h0000_0100, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
    vecs[7]  = mk(1, 32'h0000_0200, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0000_3000);
    vecs[8]  = mk(1, 32'h0000_0140, 1, 32'h0000_0140, 32'h0000_4000, 1, 0, 0, 0, 32'h0);
    vecs[9]  = mk(1, 32'h0000_0140, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0000_4000);
    vecs[10] = mk(1, 32'h0000_0180, 1, 32'h0000_0180, 32'h0000_6000, 0, 0, 0, 0, 32'h0);
    vecs[11] = mk(1, 32'h0000_0180, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
    // flush: registered build drops the lookup, combinational build ignores it
    vecs[12] = mk(1, 32'h0000_0200, 0, 32'h0,        32'h0,        0, 0, 1,
                  REG_MODE ? 1'b0 : 1'b1, REG_MODE ? 32'h0 : 32'h0000_3000);
    vecs[13] = mk(1, 32'h0000_0200, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0000_3000);
    vecs[14] = mk(0, 32'h0000_0200, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
    // invalidate with simultaneous taken update; same-cycle lookup sees old table
    vecs[15] = mk(1, 32'h0000_0200, 1, 32'h0000_01C0, 32'h0000_5000, 1, 1, 0, 1, 32'h0000_3000);
    vecs[16] = mk(1, 32'h0000_0100, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
    vecs[17] = mk(1, 32'h0000_0200, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
    vecs[18] = mk(1, 32'h0000_01C0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
    vecs[19] = mk(1, 32'h0000_0140, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
    // top-of-address boundary: all tag bits set, low offset bits ignored
    vecs[20] = mk(0, 32'h0,         1, 32'hFFFF_FFFC, 32'h1234_5678, 1, 0, 0, 0, 32'h0);
    vecs[21] = mk(1, 32'hFFFF_FFFF, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h1234_5678);
    vecs[22] = mk(1, 32'h7FFF_FFFC, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);

    reset_         = 1'b0;
    flush_         = 1'b1;
    inv_           = 1'b1;
    bus.lk_        = 1'b1;
    bus.lk_addr    = 32'h0;
    bus.upd_       = 1'b1;
    bus.upd_addr   = 32'h0;
    bus.upd_target = 32'h0;
    bus.upd_taken_ = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 1'b0, 32'h0);
    @(negedge clk);
    reset_ = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-operation: train, hit, then reset between edges.
    step(mk(0, 32'h0, 1, 32'h0000_0100, 32'h0000_2000, 1, 0, 0, 0, 32'h0), "rst_train");
    step(mk(1, 32'h0000_0100, 0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0000_2000), "rst_prehit");
    #2;
    reset_ = 1'b0;
    #1;
    chk("rst_async_clear", 1'b0, 32'h0);
    @(negedge clk);
    reset_ = 1'b1;
    step(mk(1, 32'h0000_0100, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0), "rst_valid_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
